// File: rtl/ins_mem_resp_pkg.sv
// Shared types and constants for the instruction-memory responder.
package ins_mem_resp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StWait,
    StResp
  } state_e;

  localparam int unsigned WaitMin = 1;
  localparam int unsigned WaitMax = 7;
  localparam int unsigned WcntW   = 3;

  // Read latency must fit the 3-bit wait counter and be at least one cycle
  function automatic bit wait_ok(input int unsigned w);
    return (w >= WaitMin) && (w <= WaitMax);
  endfunction

endpackage

// File: rtl/ins_mem_resp_if.sv
// Fetch and loader bus between the fetch unit (master) and the memory responder (slave).
interface ins_mem_resp_if #(
  parameter int unsigned ADDR_W = 10
) ();

  logic              req;
  logic [31:0]       ins_ad;
  logic [31:0]       ins_mem;
  logic              ins_valid;
  logic              busy;
  logic              misalign;
  logic              ld_en;
  logic              ld_strobe;
  logic [7:0]        ld_byte;
  logic [ADDR_W:0]   ld_count;

  modport master (
    output req, ins_ad, ld_en, ld_strobe, ld_byte,
    input  ins_mem, ins_valid, busy, misalign, ld_count
  );

  modport slave (
    input  req, ins_ad, ld_en, ld_strobe, ld_byte,
    output ins_mem, ins_valid, busy, misalign, ld_count
  );

endinterface

// File: rtl/ins_mem_resp_ram.sv
// Single-port 2**ADDR_W x 32 RAM with a synchronous, enable-gated read register.
// The read register holds its value between reads so it can drive ins_mem directly.
module ins_mem_resp_ram #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_re,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [0:(1 << ADDR_W) - 1];
  logic [31:0] r_rdata;

  // Storage array: written by the loader, never cleared by reset
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Read register: updates only on a read, so the last response is held
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ins_mem_resp.sv
// Instruction-memory responder: serves word fetches after WAIT cycles with a
// one-cycle ins_valid pulse, and fills memory from a byte-serial loader.
module ins_mem_resp
  import ins_mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned WAIT   = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  ins_mem_resp_if.slave bus
);

  localparam logic [WcntW-1:0] WcntInit   = WcntW'((WAIT >= 2) ? (WAIT - 2) : 0);
  localparam logic [ADDR_W:0]  LdCountMax = {1'b1, {ADDR_W{1'b0}}};

  if (!wait_ok(WAIT)) begin : g_wait_range
    $error("ins_mem_resp: WAIT must be within 1..7");
  end

  state_e              r_state, w_state_d;
  logic [ADDR_W-1:0]   r_addr, w_addr_d;
  logic [WcntW-1:0]    r_wcnt, w_wcnt_d;
  logic                r_misalign, w_misalign_d;
  logic [ADDR_W-1:0]   r_ptr, w_ptr_d;
  logic [1:0]          r_lane, w_lane_d;
  logic [23:0]         r_word, w_word_d;
  logic [ADDR_W:0]     r_ld_count, w_ld_count_d;
  logic                r_valid, r_busy;

  logic                w_ram_re, w_ram_we;
  logic [ADDR_W-1:0]   w_ram_addr;
  logic [31:0]         w_ram_wdata, w_rdata;
  logic                w_unused_ad;

  // Address bits above the RAM depth wrap and are deliberately dropped
  assign w_unused_ad = ^bus.ins_ad[31:ADDR_W+2];

  // Next-state, RAM control and loader assembly
  always_comb begin
    w_state_d     = r_state;
    w_addr_d      = r_addr;
    w_wcnt_d      = r_wcnt;
    w_misalign_d  = r_misalign;
    w_ptr_d       = r_ptr;
    w_lane_d      = r_lane;
    w_word_d      = r_word;
    w_ld_count_d  = r_ld_count;
    w_ram_re      = 1'b0;
    w_ram_we      = 1'b0;
    w_ram_addr    = r_addr;
    w_ram_wdata   = {bus.ld_byte, r_word};

    unique case (r_state)
      // RESP accepts like IDLE so back-to-back fetches need no gap
      StIdle, StResp: begin
        if (bus.ld_en) begin
          w_state_d    = StLoad;
          w_ptr_d      = '0;
          w_lane_d     = '0;
          w_ld_count_d = '0;
        end else if (bus.req) begin
          w_addr_d = bus.ins_ad[ADDR_W+1:2];
          if (bus.ins_ad[1:0] != 2'b00) begin
            w_misalign_d = 1'b1;
          end
          if (WAIT == 1) begin
            // Single-cycle latency: read straight from the incoming address
            w_state_d  = StResp;
            w_ram_re   = 1'b1;
            w_ram_addr = bus.ins_ad[ADDR_W+1:2];
          end else begin
            w_state_d = StWait;
            w_wcnt_d  = WcntInit;
          end
        end else begin
          w_state_d = StIdle;
        end
      end
      StWait: begin
        // Issue the read in the last wait cycle so data lands with ins_valid
        if (r_wcnt == '0) begin
          w_ram_re  = 1'b1;
          w_state_d = StResp;
        end else begin
          w_wcnt_d = r_wcnt - WcntW'(1);
        end
      end
      StLoad: begin
        w_ram_addr = r_ptr;
        if (!bus.ld_en) begin
          w_state_d = StIdle;
          w_lane_d  = '0;
        end else if (bus.ld_strobe) begin
          if (r_lane == 2'd3) begin
            w_ram_we = ~i_rst;
            w_ptr_d  = r_ptr + ADDR_W'(1);
            w_lane_d = '0;
            if (r_ld_count != LdCountMax) begin
              w_ld_count_d = r_ld_count + (ADDR_W + 1)'(1);
            end
          end else begin
            w_lane_d                      = r_lane + 2'd1;
            w_word_d[{r_lane, 3'b000} +: 8] = bus.ld_byte;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State and registered-output update with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_wcnt     <= '0;
      r_misalign <= 1'b0;
      r_ptr      <= '0;
      r_lane     <= '0;
      r_word     <= '0;
      r_ld_count <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_addr     <= w_addr_d;
      r_wcnt     <= w_wcnt_d;
      r_misalign <= w_misalign_d;
      r_ptr      <= w_ptr_d;
      r_lane     <= w_lane_d;
      r_word     <= w_word_d;
      r_ld_count <= w_ld_count_d;
      r_valid    <= (w_state_d == StResp);
      r_busy     <= (w_state_d == StWait) || (w_state_d == StLoad);
    end
  end

  ins_mem_resp_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_re    (w_ram_re),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_rdata)
  );

  assign bus.ins_mem   = w_rdata;
  assign bus.ins_valid = r_valid;
  assign bus.busy      = r_busy;
  assign bus.misalign  = r_misalign;
  assign bus.ld_count  = r_ld_count;

endmodule

// File: tb/tb_ins_mem_resp.sv
// Bench for ins_mem_resp: two instances (WAIT=1 and WAIT=3) share one stimulus
// stream; a timestamp-based reference model predicts every output each cycle.
module tb_ins_mem_resp;

  localparam int unsigned AW    = 10;
  localparam int          Depth = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ins_mem_resp_if #(.ADDR_W(AW)) u_if1 ();
  ins_mem_resp_if #(.ADDR_W(AW)) u_if3 ();

  ins_mem_resp #(.ADDR_W(AW), .WAIT(1)) u_dut1 (.i_clk(clk), .i_rst(rst), .bus(u_if1.slave));
  ins_mem_resp #(.ADDR_W(AW), .WAIT(3)) u_dut3 (.i_clk(clk), .i_rst(rst), .bus(u_if3.slave));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model, index 0 -> WAIT=1, index 1 -> WAIT=3
  int          wlat [2] = '{1, 3};
  logic [31:0] m_mem [2][Depth];
  longint      m_acc_t [2];
  longint      m_resp_at [2];
  logic [31:0] m_resp_data [2];
  logic [31:0] m_cur [2];
  bit          m_mis [2];
  bit          m_load [2];
  int          m_lane [2];
  int          m_ptr [2];
  int          m_cnt [2];
  logic [31:0] m_word [2];
  longint      cyc = 0;
  bit          chk_en = 1'b0;

  task automatic model_reset(input int d);
    m_acc_t[d]   = -100;
    m_resp_at[d] = -1;
    m_cur[d]     = '0;
    m_mis[d]     = 1'b0;
    m_load[d]    = 1'b0;
    m_lane[d]    = 0;
    m_ptr[d]     = 0;
    m_cnt[d]     = 0;
    m_word[d]    = '0;
  endtask

  task automatic compare_outputs();
    logic [31:0] o_mem [2];
    logic        o_val [2];
    logic        o_busy [2];
    logic        o_mis [2];
    logic [AW:0] o_cnt [2];
    bit          e_busy;
    o_mem[0] = u_if1.ins_mem;  o_val[0] = u_if1.ins_valid; o_busy[0] = u_if1.busy;
    o_mis[0] = u_if1.misalign; o_cnt[0] = u_if1.ld_count;
    o_mem[1] = u_if3.ins_mem;  o_val[1] = u_if3.ins_valid; o_busy[1] = u_if3.busy;
    o_mis[1] = u_if3.misalign; o_cnt[1] = u_if3.ld_count;
    for (int d = 0; d < 2; d++) begin
      if (m_resp_at[d] == cyc) m_cur[d] = m_resp_data[d];
    end
    if (!chk_en) return;
    for (int d = 0; d < 2; d++) begin
      e_busy = m_load[d] || (cyc > m_acc_t[d] && cyc < m_acc_t[d] + wlat[d]);
      check_eq($sformatf("w%0d_ins_valid@%0d", wlat[d], cyc), 32'(o_val[d]),
               32'(m_resp_at[d] == cyc));
      check_eq($sformatf("w%0d_ins_mem@%0d", wlat[d], cyc), o_mem[d], m_cur[d]);
      check_eq($sformatf("w%0d_busy@%0d", wlat[d], cyc), 32'(o_busy[d]), 32'(e_busy));
      check_eq($sformatf("w%0d_misalign@%0d", wlat[d], cyc), 32'(o_mis[d]), 32'(m_mis[d]));
      check_eq($sformatf("w%0d_ld_count@%0d", wlat[d], cyc), 32'(o_cnt[d]), 32'(m_cnt[d]));
    end
  endtask

  task automatic step_model(input bit r, input bit rq, input logic [31:0] ad, input bit le,
                            input bit ls, input logic [7:0] lb);
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        model_reset(d);
      end else if (m_load[d]) begin
        if (!le) begin
          m_load[d] = 1'b0;
          m_lane[d] = 0;
        end else if (ls) begin
          m_word[d][8*m_lane[d] +: 8] = lb;
          if (m_lane[d] == 3) begin
            m_mem[d][m_ptr[d]] = m_word[d];
            m_ptr[d]  = (m_ptr[d] + 1) % Depth;
            m_cnt[d]  = (m_cnt[d] < Depth) ? m_cnt[d] + 1 : Depth;
            m_lane[d] = 0;
          end else begin
            m_lane[d]++;
          end
        end
      end else if (cyc >= m_acc_t[d] + wlat[d]) begin
        if (le) begin
          m_load[d] = 1'b1;
          m_lane[d] = 0;
          m_ptr[d]  = 0;
          m_cnt[d]  = 0;
        end else if (rq) begin
          m_acc_t[d]     = cyc;
          m_resp_at[d]   = cyc + wlat[d];
          m_resp_data[d] = m_mem[d][(ad >> 2) % Depth];
          if (ad[1:0] != 2'b00) m_mis[d] = 1'b1;
        end
      end
    end
  endtask

  // One clock cycle: check outputs, drive inputs, advance model, then move past the edge
  task automatic tick(input bit r, input bit rq, input logic [31:0] ad, input bit le,
                      input bit ls, input logic [7:0] lb);
    compare_outputs();
    rst = r;
    u_if1.req = rq; u_if1.ins_ad = ad; u_if1.ld_en = le; u_if1.ld_strobe = ls;
    u_if1.ld_byte = lb;
    u_if3.req = rq; u_if3.ins_ad = ad; u_if3.ld_en = le; u_if3.ld_strobe = ls;
    u_if3.ld_byte = lb;
    step_model(r, rq, ad, le, ls, lb);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
  endtask

  logic [7:0] prog [8] = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};

  initial begin
    bit          le;
    bit          rq;
    logic [31:0] ad;
    for (int d = 0; d < 2; d++) model_reset(d);
    u_if1.req = 0; u_if1.ins_ad = 0; u_if1.ld_en = 0; u_if1.ld_strobe = 0; u_if1.ld_byte = 0;
    u_if3.req = 0; u_if3.ins_ad = 0; u_if3.ld_en = 0; u_if3.ld_strobe = 0; u_if3.ld_byte = 0;
    @(posedge clk);
    #1;

    // Reset held for two edges, then everything must read zero
    tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
    chk_en = 1'b1;
    check_eq("rst_ins_mem", u_if1.ins_mem, 32'h0);
    check_eq("rst_ins_valid", 32'(u_if3.ins_valid), 32'h0);
    check_eq("rst_busy", 32'(u_if3.busy), 32'h0);
    check_eq("rst_ld_count", 32'(u_if1.ld_count), 32'h0);

    // Fill all of memory plus one word: pointer wraps, ld_count saturates
    tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 8'h00);
    for (int w = 0; w <= Depth; w++) begin
      for (int b = 0; b < 4; b++) tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 8'($urandom));
    end
    check_eq("wrap_ld_count", 32'(u_if1.ld_count), 32'd1024);
    tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);

    // Program load of two words
    idle(1);
    tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, prog[i]);
    check_eq("prog_ld_count", 32'(u_if3.ld_count), 32'd2);
    tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);

    // Aborted partial word must not disturb mem[0]
    tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 8'hAA);
    tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 8'hBB);
    tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
    idle(2);
    tick(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 8'h00);
    check_eq("w1_mem0_valid", 32'(u_if1.ins_valid), 32'h1);
    check_eq("w1_mem0", u_if1.ins_mem, 32'h00100513);
    idle(2);
    check_eq("w3_mem0_valid", 32'(u_if3.ins_valid), 32'h1);
    check_eq("w3_mem0", u_if3.ins_mem, 32'h00100513);

    // Fetch 0x4; second req lands in W1 RESP (accepted) and W3 WAIT (ignored)
    idle(1);
    tick(1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 8'h00);
    check_eq("w1_fetch4", u_if1.ins_mem, 32'h00200593);
    tick(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 8'h00);
    check_eq("w1_b2b_valid", 32'(u_if1.ins_valid), 32'h1);
    check_eq("w1_b2b_mem", u_if1.ins_mem, 32'h00100513);
    idle(1);
    check_eq("w3_fetch4", u_if3.ins_mem, 32'h00200593);
    idle(1);
    check_eq("w3_no_extra_pulse", 32'(u_if3.ins_valid), 32'h0);

    // Misaligned, out-of-range address wraps to word 0
    idle(2);
    tick(1'b0, 1'b1, 32'h1002, 1'b0, 1'b0, 8'h00);
    idle(2);
    check_eq("w3_wrap_mem", u_if3.ins_mem, 32'h00100513);
    check_eq("w1_misalign", 32'(u_if1.misalign), 32'h1);

    // ld_en beats a simultaneous req
    idle(3);
    tick(1'b0, 1'b1, 32'h4, 1'b1, 1'b0, 8'h00);
    check_eq("prio_busy", 32'(u_if1.busy), 32'h1);
    check_eq("prio_no_valid", 32'(u_if1.ins_valid), 32'h0);
    tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
    idle(3);

    // Reset while W3 is waiting drops the response; RAM survives
    tick(1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
    check_eq("rstw_mem_clr", u_if3.ins_mem, 32'h0);
    idle(1);
    check_eq("rstw_no_valid", 32'(u_if3.ins_valid), 32'h0);
    check_eq("rstw_misalign_clr", 32'(u_if3.misalign), 32'h0);
    tick(1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 8'h00);
    idle(2);
    check_eq("rstw_refetch_valid", 32'(u_if3.ins_valid), 32'h1);
    check_eq("rstw_refetch_mem", u_if3.ins_mem, 32'h00200593);

    // Randomized traffic: fetches, loader bursts and occasional resets
    le = 1'b0;
    repeat (600) begin
      if ($urandom_range(0, 15) == 0) le = !le;
      rq = 1'($urandom_range(0, 1));
      ad = $urandom();
      tick(1'($urandom_range(0, 99) == 0), rq, ad, le, 1'($urandom_range(0, 1)),
           8'($urandom));
    end
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
